// File: rtl/fp_mul_arbiter.sv
// Two-requester round-robin arbiter in front of one non-pipelined FP multiplier.
// Define FP_MUL_ARB_TIMEOUT_EN to enable the WAIT_Z watchdog (quiet-NaN abort, sticky timeout_err).
module fp_mul_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_stb,
    output logic        req0_ack,
    output logic [31:0] req0_z,
    output logic        req0_z_stb,
    input  logic        req0_z_ack,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_stb,
    output logic        req1_ack,
    output logic [31:0] req1_z,
    output logic        req1_z_stb,
    input  logic        req1_z_ack,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_a_stb,
    output logic        mul_b_stb,
    input  logic        mul_a_ack,
    input  logic        mul_b_ack,
    input  logic [31:0] mul_z,
    input  logic        mul_z_stb,
    output logic        mul_z_ack,
    output logic        busy,
    output logic        timeout_err
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_timeout_range
        $error("fp_mul_arbiter: TIMEOUT must be in 2..65535");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Z, RETURN} state_t;

    state_t      state;
    logic        owner;
    logic        last;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] res;
    logic        grant;
    logic        z_take;
    logic        tmo_hit;

    // A single requester wins outright; a tie goes to the one not served last.
    assign grant  = (req0_stb && req1_stb) ? !last : req1_stb;
    // While our own ack pulse is out, a still-high mul_z_stb is the same result, not a new one.
    assign z_take = (state == WAIT_Z) && mul_z_stb && !mul_z_ack;

    assign mul_a  = op_a;
    assign mul_b  = op_b;
    assign req0_z = req0_z_stb ? res : '0;
    assign req1_z = req1_z_stb ? res : '0;
    assign busy   = (state != IDLE);

`ifdef FP_MUL_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt;

    assign tmo_hit = (state == WAIT_Z) && !z_take && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == WAIT_Z) ? tmo_cnt + 16'd1 : '0;
            if (tmo_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            res        <= '0;
            req0_ack   <= 1'b0;
            req1_ack   <= 1'b0;
            req0_z_stb <= 1'b0;
            req1_z_stb <= 1'b0;
            mul_a_stb  <= 1'b0;
            mul_b_stb  <= 1'b0;
            mul_z_ack  <= 1'b0;
        end else begin
            req0_ack  <= 1'b0;
            req1_ack  <= 1'b0;
            mul_z_ack <= 1'b0;
            if (mul_z_stb && !mul_z_ack && state != WAIT_Z)
                mul_z_ack <= 1'b1;

            case (state)
                IDLE: begin
                    if (req0_stb || req1_stb) begin
                        owner     <= grant;
                        last      <= grant;
                        op_a      <= grant ? req1_a : req0_a;
                        op_b      <= grant ? req1_b : req0_b;
                        req0_ack  <= !grant;
                        req1_ack  <= grant;
                        mul_a_stb <= 1'b1;
                        mul_b_stb <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_a_ack)
                        mul_a_stb <= 1'b0;
                    if (mul_b_ack)
                        mul_b_stb <= 1'b0;
                    if ((!mul_a_stb || mul_a_ack) && (!mul_b_stb || mul_b_ack))
                        state <= WAIT_Z;
                end
                WAIT_Z: begin
                    if (z_take) begin
                        res        <= mul_z;
                        mul_z_ack  <= 1'b1;
                        req0_z_stb <= !owner;
                        req1_z_stb <= owner;
                        state      <= RETURN;
                    end else if (tmo_hit) begin
                        res        <= 32'h7FC0_0000;
                        req0_z_stb <= !owner;
                        req1_z_stb <= owner;
                        state      <= RETURN;
                    end
                end
                RETURN: begin
                    if (owner ? req1_z_ack : req0_z_ack) begin
                        req0_z_stb <= 1'b0;
                        req1_z_stb <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Two-requester round-robin arbiter that shares one `fp_multiplier`-class unit. The unit is non-pipelined, with separate `a`/`b` operand handshakes and a `z` result handshake. The arbiter accepts an operand pair from a requester, issues it to the multiplier, and routes the product back to the same requester. It sits between the datapath clients and the single shared FP multiplier and keeps at most one operation in flight.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles the arbiter waits in WAIT_Z before aborting. Used only when `FP_MUL_ARB_TIMEOUT_EN` is defined. Legal range 2..65535.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req0_a`, `req0_b`  in  32 each  IEEE-754 single operands from requester 0.
- `req0_stb`  in  1  requester 0 has a valid operand pair.
- `req0_ack`  out  1  one-cycle pulse: pair accepted.
- `req0_z`  out  32  product returned to requester 0.
- `req0_z_stb`  out  1  `req0_z` is valid.
- `req0_z_ack`  in  1  requester 0 has taken the result.
- `req1_*`  same as `req0_*`, for requester 1.
- `mul_a`, `mul_b`  out  32 each  operands to the multiplier.
- `mul_a_stb`, `mul_b_stb`  out  1 each  operand valid.
- `mul_a_ack`, `mul_b_ack`  in  1 each  multiplier accepted the operand.
- `mul_z`  in  32  multiplier result.
- `mul_z_stb`  in  1  result valid.
- `mul_z_ack`  out  1  one-cycle pulse: result taken.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  sticky error flag; clears only on `rst`.

## Operation
States: IDLE, ISSUE, WAIT_Z, RETURN. Registers:
- `owner` (1 bit)
- `last` (1 bit)
- operand registers (32 bits each)
- result register (32 bits)
- timeout counter (16 bits)

Transitions:
- **IDLE**
  - Only one `reqN_stb` sampled high: grant that requester.
  - Both sampled high: grant `!last`.
  - On grant: latch the operands, set `owner` and `last` to the granted index, pulse `reqN_ack`, assert `mul_a_stb` and `mul_b_stb`, go to ISSUE.
- **ISSUE**
  - `mul_a`/`mul_b` come from the operand registers and stay stable while their strobe is high.
  - Each `mul_x_stb` drops on the cycle after its `mul_x_ack` is sampled high; the two acks may arrive in any order or together.
  - When both operands are acknowledged, go to WAIT_Z.
- **WAIT_Z**
  - `mul_z_stb` sampled high: capture `mul_z`, pulse `mul_z_ack`, assert `req<owner>_z_stb`, go to RETURN.
- **RETURN**
  - Hold `req<owner>_z` and `req<owner>_z_stb` until `req<owner>_z_ack` is sampled high.
  - Then drop the strobe and go to IDLE.

Rules applying in all states:
- The non-owner's `stb` is ignored until IDLE; the non-owner's `z` and `z_stb` stay 0.
- `reqN_z_ack` is ignored unless `reqN_z_stb` is high.
- `mul_z_stb` seen outside WAIT_Z is a stale result: the arbiter pulses `mul_z_ack` and discards the data.
- No arithmetic is performed on operands or result; all values pass through bit-exact.

## Timing
- Reset values: every output 0, state IDLE, `last`=1 (so requester 0 wins the first tie), counter 0.
- Reset asserted mid-operation: the operation is abandoned immediately and no result is delivered. The multiplier must share `rst`.
- Requester stb sampled high at cycle T in IDLE gives:
  - `reqN_ack` high during T+1 only;
  - `mul_a_stb` and `mul_b_stb` high from T+1.
- Requester must drop `stb` (or present a new pair) after seeing `ack`. A held `stb` is treated as a new request at the next IDLE.
- `mul_z_stb` sampled at cycle W gives `mul_z_ack` and `reqN_z_stb` high at W+1.
- `reqN_z_ack` sampled at cycle R gives `reqN_z_stb` low and IDLE at R+1. The earliest next grant is sampled at R+1, with ack at R+2.
- Overhead is 3 cycles beyond multiplier latency plus requester response time.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.

## Configuration
`FP_MUL_ARB_TIMEOUT_EN`:
- **Defined:**
  - The counter clears on entry to WAIT_Z and increments each cycle there.
  - If it reaches `TIMEOUT` with `mul_z_stb` still low: return `32'h7FC00000` (quiet NaN) to the owner through the normal RETURN handshake, and set `timeout_err`.
  - A late multiplier result is later drained by the stale-result rule.
- **Undefined:** no counter; WAIT_Z waits indefinitely; `timeout_err` is tied to 0.

## Test plan
- Single request: req0 sends `40000000`×`40400000`; multiplier model returns `40C00000` after 5 cycles. Expect `req0_ack` pulse, `req0_z`=`40C00000`, req1 outputs 0, `busy` low after `z_ack`.
- Tie: both stb in the same cycle after reset. req0 (`3FC00000`×`3FC00000`→`40100000`) is served first, then req1 (`C0000000`×`40800000`→`C1000000`). Each result is routed only to its owner.
- Continuous contention over 8 operations: grant order 0,1,0,1,0,1,0,1.
- Skewed operand acks: `mul_b_ack` arrives 3 cycles after `mul_a_ack`. `mul_a_stb` drops a cycle before `mul_b_stb`; state stays ISSUE until both are acked; operands stay stable.
- Backpressure and reset: req1 holds `z_ack` low for 10 cycles; result is held stable and req0's stb is ignored. Then `rst` pulsed during WAIT_Z: all outputs 0 next edge, no result delivered.
- With `FP_MUL_ARB_TIMEOUT_EN`, `TIMEOUT`=8: multiplier never answers. Expect `req0_z`=`7FC00000` and `timeout_err`=1. A late `mul_z_stb` is acked and discarded.
